// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants for the multi-port register file
package regfile_mp_pkg;

  localparam int ZERO_ADDR = 0;
  localparam int MAX_RD    = 4;
  localparam int MAX_WR    = 2;

  // Full-width range check; the compare never truncates the address.
  function automatic bit addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with range check, zero forcing and byte bypass
module regfile_read_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                            rst_n,
  input  logic [ADDR_BITS-1:0]            raddr,
  input  logic [DATA_BITS-1:0]            stored,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*ADDR_BITS-1:0]     waddr,
  input  logic [NUM_WR*DATA_BITS-1:0]     wdata,
  input  logic [NUM_WR*(DATA_BITS/8)-1:0] wstrb,
  output logic [DATA_BITS-1:0]            rdata
);

  localparam int BYTES = DATA_BITS / 8;

  logic                 in_range;
  logic                 is_zero;
  logic [DATA_BITS-1:0] merged;

  assign in_range = addr_in_range(32'(raddr), DEPTH);
  assign is_zero  = (ZERO_REG != 0) && (raddr == ADDR_BITS'(ZERO_ADDR));

  // Later write ports overlay earlier ones, matching the array's write priority.
  always_comb begin
    merged = stored;
    if (BYPASS != 0 && rst_n) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && waddr[k*ADDR_BITS +: ADDR_BITS] == raddr) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wstrb[k*BYTES + b]) begin
              merged[b*8 +: 8] = wdata[k*DATA_BITS + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign rdata = (!rst_n || !in_range || is_zero) ? '0 : merged;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with byte strobes, bypass and debug read
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*ADDR_BITS-1:0]     waddr,
  input  logic [NUM_WR*DATA_BITS-1:0]     wdata,
  input  logic [NUM_WR*(DATA_BITS/8)-1:0] wstrb,
  input  logic [NUM_RD*ADDR_BITS-1:0]     raddr,
  output logic [NUM_RD*DATA_BITS-1:0]     rdata,
  input  logic [ADDR_BITS-1:0]            dbg_addr,
  output logic [DATA_BITS-1:0]            dbg_data
);

  localparam int BYTES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] regs [DEPTH];
  logic [NUM_WR-1:0]    wr_ok;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    logic [ADDR_BITS-1:0] wa;
    assign wa       = waddr[k*ADDR_BITS +: ADDR_BITS];
    assign wr_ok[k] = we[k] && addr_in_range(32'(wa), DEPTH) &&
                      !((ZERO_REG != 0) && (wa == ADDR_BITS'(ZERO_ADDR)));
  end

  // Ports are visited in index order so the higher port's byte lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wstrb[k*BYTES + b]) begin
              regs[waddr[k*ADDR_BITS +: ADDR_BITS]][b*8 +: 8] <= wdata[k*DATA_BITS + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_BITS-1:0] ra;
    logic [DATA_BITS-1:0] stored;
    assign ra     = raddr[p*ADDR_BITS +: ADDR_BITS];
    assign stored = addr_in_range(32'(ra), DEPTH) ? regs[ra] : '0;

    regfile_read_port #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS),
      .DEPTH     (DEPTH),
      .NUM_WR    (NUM_WR),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_rd (
      .rst_n  (rst_n),
      .raddr  (ra),
      .stored (stored),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .rdata  (rdata[p*DATA_BITS +: DATA_BITS])
    );
  end

  assign dbg_data = addr_in_range(32'(dbg_addr), DEPTH) ? regs[dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with two parameter sets
module tb_regfile_mp;

  localparam int AB = 5;
  localparam int NW = 2;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NW-1:0]    we = '0;
  logic [NW*AB-1:0] waddr = '0;
  logic [NW*32-1:0] wdata = '0;
  logic [NW*4-1:0]  wstrb = '0;
  logic [NR*AB-1:0] raddr = '0;
  logic [AB-1:0]    dbg_addr = '0;
  logic [NR*32-1:0] rdata_a, rdata_b;
  logic [31:0]      dbg_a, dbg_b;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_BITS(32), .ADDR_BITS(AB), .DEPTH(24), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr), .rdata(rdata_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a));

  regfile_mp #(.DATA_BITS(32), .ADDR_BITS(AB), .DEPTH(32), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr), .rdata(rdata_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] rd_a0, rd_a1, dbg_a, rd_b0, rd_b1, dbg_b;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: instance 0 = depth 24, zero reg, bypass; instance 1 = depth 32, plain.
  logic [31:0] mem [2][32];
  int depth_i [2] = '{24, 32};
  bit zero_i  [2] = '{1'b1, 1'b0};
  bit byp_i   [2] = '{1'b1, 1'b0};

  function automatic logic [31:0] overlay(input logic [31:0] base, input logic [4:0] a);
    logic [31:0] v = base;
    for (int k = 0; k < NW; k++)
      if (we[k] && waddr[k*AB +: AB] == a)
        for (int b = 0; b < 4; b++)
          if (wstrb[k*4 + b]) v[b*8 +: 8] = wdata[k*32 + b*8 +: 8];
    return v;
  endfunction

  function automatic bit usable(input int i, input logic [4:0] a);
    return (int'(a) < depth_i[i]) && !(zero_i[i] && a == 5'd0);
  endfunction

  function automatic logic [31:0] model_rd(input int i, input logic [4:0] a);
    if (!rst_n || !usable(i, a)) return 32'h0;
    return byp_i[i] ? overlay(mem[i][a], a) : mem[i][a];
  endfunction

  function automatic logic [31:0] model_dbg(input int i, input logic [4:0] a);
    if (int'(a) >= depth_i[i]) return 32'h0;
    return mem[i][a];
  endfunction

  task automatic commit();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NW; k++)
        if (rst_n && we[k] && usable(i, waddr[k*AB +: AB]))
          mem[i][waddr[k*AB +: AB]] = overlay(mem[i][waddr[k*AB +: AB]], waddr[k*AB +: AB]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) mem[i][r] = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Drive one cycle (called at posedge+1), queue its expected reads, then retire the write.
  task automatic cyc(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [3:0] s0, input logic [3:0] s1,
                     input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da);
    exp_t e;
    we = w; waddr = {wa1, wa0}; wdata = {wd1, wd0}; wstrb = {s1, s0};
    raddr = {ra1, ra0}; dbg_addr = da;
    cyc_no++;
    e.id = 32'(cyc_no);
    e.rd_a0 = model_rd(0, ra0); e.rd_a1 = model_rd(0, ra1); e.dbg_a = model_dbg(0, da);
    e.rd_b0 = model_rd(1, ra0); e.rd_b1 = model_rd(1, ra1); e.dbg_b = model_dbg(1, da);
    exp_q.push_back(e);
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da);
    cyc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, ra0, ra1, da);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd_a0", e.id, rdata_a[31:0],  e.rd_a0);
      chk("rd_a1", e.id, rdata_a[63:32], e.rd_a1);
      chk("dbg_a", e.id, dbg_a,          e.dbg_a);
      chk("rd_b0", e.id, rdata_b[31:0],  e.rd_b0);
      chk("rd_b1", e.id, rdata_b[63:32], e.rd_b1);
      chk("dbg_b", e.id, dbg_b,          e.dbg_b);
    end
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rd(5'd0, 5'd5, 5'd5);
    rst_n = 1'b1;
    rd(5'd1, 5'd31, 5'd23);

    // Reset behaviour
    cyc(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 5'd5, 5'd5, 5'd5);
    rd(5'd5, 5'd5, 5'd5);
    rst_n = 1'b0; clear_model();
    cyc(2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 4'hF, 4'h0, 5'd5, 5'd5, 5'd5);
    rst_n = 1'b1;
    rd(5'd5, 5'd5, 5'd5);

    // Byte strobes
    cyc(2'b01, 5'd7, 5'd0, 32'h11223344, 32'h0, 4'hF, 4'h0, 5'd7, 5'd7, 5'd7);
    cyc(2'b01, 5'd7, 5'd0, 32'hAABBCCDD, 32'h0, 4'b0101, 4'h0, 5'd7, 5'd7, 5'd7);
    rd(5'd7, 5'd7, 5'd7);
    cyc(2'b01, 5'd7, 5'd0, 32'hFFFFFFFF, 32'h0, 4'h0, 4'h0, 5'd7, 5'd7, 5'd7);
    rd(5'd7, 5'd7, 5'd7);

    // Bypass versus stored value
    cyc(2'b01, 5'd9, 5'd0, 32'hCAFEF00D, 32'h0, 4'hF, 4'h0, 5'd9, 5'd9, 5'd9);
    cyc(2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0, 4'hF, 4'h0, 5'd9, 5'd1, 5'd9);
    rd(5'd9, 5'd9, 5'd9);

    // Zero register
    cyc(2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 4'hF, 5'd0, 5'd0, 5'd0);
    rd(5'd0, 5'd0, 5'd0);

    // Dual write merge
    cyc(2'b11, 5'd3, 5'd3, 32'hAAAAAAAA, 32'h55555555, 4'hF, 4'h3, 5'd3, 5'd3, 5'd3);
    rd(5'd3, 5'd3, 5'd3);

    // Out-of-range addresses on the 24-deep instance
    cyc(2'b11, 5'd30, 5'd24, 32'h0BADF00D, 32'h76543210, 4'hF, 4'hF, 5'd30, 5'd24, 5'd30);
    rd(5'd30, 5'd24, 5'd24);
    rd(5'd23, 5'd3, 5'd7);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa0, wa1, ra0, ra1;
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0; clear_model();
      end
      cyc(2'($urandom), wa0, wa1, $urandom, $urandom, 4'($urandom), 4'($urandom),
          ra0, ra1, 5'($urandom_range(0, 31)));
      rst_n = 1'b1;
    end

    rd(5'd0, 5'd1, 5'd2);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(cyc_no), 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
